// File: rtl/dot_engine.sv
// Streaming signed dot-product stage: consumes interleaved W/X words,
// multiply-accumulates vec_len pairs and returns one result word.
module dot_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic                  src_vld,
  output logic                  src_rdy,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  result_vld,
  input  logic                  result_rdy,
  output logic [ACC_WIDTH-1:0]  result_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GET_W,
    S_GET_X,
    S_RESULT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0]          r_w;
  logic [ACC_WIDTH-1:0]           r_acc;
  logic [LEN_WIDTH-1:0]           r_cnt;
  logic [ACC_WIDTH-1:0]           r_res;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;
  logic [ACC_WIDTH-1:0]           w_sum;
  logic                           w_last;

  assign w_prod     = $signed(r_w) * $signed(src_data);
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_last     = (r_cnt == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (vec_len != '0) ? S_GET_W : S_RESULT;
      end
      S_GET_W: begin
        if (src_vld) w_next = S_GET_X;
      end
      S_GET_X: begin
        if (src_vld) w_next = w_last ? S_RESULT : S_GET_W;
      end
      S_RESULT: begin
        if (result_rdy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    src_rdy    = 1'b0;
    result_vld = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      S_IDLE:   busy       = 1'b0;
      S_GET_W:  src_rdy    = 1'b1;
      S_GET_X:  src_rdy    = 1'b1;
      S_RESULT: result_vld = 1'b1;
      default:  busy       = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_cnt <= vec_len;
            if (vec_len == '0) r_res <= '0;
          end
        end
        S_GET_W: begin
          if (src_vld) r_w <= src_data;
        end
        S_GET_X: begin
          if (src_vld) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - LEN_WIDTH'(1);
            if (w_last) r_res <= w_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_data = r_res;

endmodule

// File: tb/tb_dot_engine.sv
// Self-checking bench for dot_engine: vector table, directed corner
// sequences and random jobs against a plain-arithmetic model.
module tb_dot_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] vec_len = '0;
  logic        src_vld = 1'b0;
  logic        src_rdy;
  logic [15:0] src_data = '0;
  logic        result_vld;
  logic        result_rdy = 1'b0;
  logic [39:0] result_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q[$];

  dot_engine #(
    .DATA_WIDTH(16),
    .ACC_WIDTH (40),
    .LEN_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_len    (vec_len),
    .src_vld    (src_vld),
    .src_rdy    (src_rdy),
    .src_data   (src_data),
    .result_vld (result_vld),
    .result_rdy (result_rdy),
    .result_data(result_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [15:0] w[4];
    logic [15:0] x[4];
    logic [39:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] model();
    longint s;
    s = 0;
    for (int i = 0; i + 1 < q.size(); i += 2)
      s += longint'($signed(q[i])) * longint'($signed(q[i+1]));
    return s[39:0];
  endfunction

  // Called on a negedge with the DUT idle; returns on the negedge
  // after the result handshake, so consecutive calls are back-to-back.
  task automatic run_job(input string nm, input int len,
                         input int bubble, input int hold,
                         input bit ign, input logic [39:0] exp);
    int idx = 0;
    int cyc = 0;
    int last = -1;
    bit bad = 0;
    bit ign_done = 0;
    logic [39:0] held;
    start = 1'b1;
    vec_len = len[15:0];
    @(negedge clk);
    while (!result_vld && cyc < 1000) begin
      if (!busy || !src_rdy) bad = 1;
      start = 1'b0;
      if (ign && !ign_done && idx == 1) begin
        start = 1'b1;
        vec_len = 16'd7;
        ign_done = 1;
      end
      if (idx < q.size() && $urandom_range(99) >= bubble) begin
        src_vld = 1'b1;
        src_data = q[idx];
      end else begin
        src_vld = 1'b0;
        src_data = 16'($urandom);
      end
      if (src_vld && src_rdy) begin
        idx++;
        last = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    src_vld = 1'b0;
    chk({nm, " result_vld"}, 64'(result_vld), 64'd1);
    chk({nm, " busy/src_rdy in job"}, 64'(bad), 64'd0);
    chk({nm, " words consumed"}, 64'(idx), 64'(q.size()));
    chk({nm, " latency"}, 64'(cyc), 64'(last + 1));
    chk({nm, " result_data"}, 64'(result_data), 64'(exp));
    held = result_data;
    bad = 0;
    src_vld = 1'b1;
    repeat (hold) begin
      if (!result_vld || result_data !== held || src_rdy || !busy)
        bad = 1;
      @(negedge clk);
    end
    if (!result_vld || result_data !== held || src_rdy) bad = 1;
    src_vld = 1'b0;
    chk({nm, " hold stable"}, 64'(bad), 64'd0);
    result_rdy = 1'b1;
    @(negedge clk);
    result_rdy = 1'b0;
    chk({nm, " idle after"}, 64'({result_vld, busy, src_rdy}), 64'd0);
  endtask

  initial begin
    vec_t tbl[6];
    int n;
    int k;

    tbl[0] = '{3, '{16'd2, 16'd4, 16'hFFFF, 16'd0},
               '{16'd3, 16'd5, 16'd7, 16'd0}, 40'd19};
    tbl[1] = '{2, '{16'h8000, 16'h7FFF, 16'd0, 16'd0},
               '{16'h8000, 16'h8000, 16'd0, 16'd0}, 40'd32768};
    tbl[2] = '{1, '{16'hFFFF, 16'd0, 16'd0, 16'd0},
               '{16'hFFFF, 16'd0, 16'd0, 16'd0}, 40'd1};
    tbl[3] = '{4, '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
               '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
               40'd4294705156};
    tbl[4] = '{1, '{16'h8000, 16'd0, 16'd0, 16'd0},
               '{16'h7FFF, 16'd0, 16'd0, 16'd0}, -40'sd1073709056};
    tbl[5] = '{2, '{16'd0, 16'd3, 16'd0, 16'd0},
               '{16'd5, 16'hFFFD, 16'd0, 16'd0}, -40'sd9};

    #12;
    chk("reset src_rdy", 64'(src_rdy), 64'd0);
    chk("reset result_vld", 64'(result_vld), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result_data", 64'(result_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      q.delete();
      for (int j = 0; j < tbl[i].len; j++) begin
        q.push_back(tbl[i].w[j]);
        q.push_back(tbl[i].x[j]);
      end
      run_job($sformatf("vec%0d", i), tbl[i].len, 0, 0, 0, tbl[i].exp);
    end

    q.delete();
    run_job("zero_len", 0, 0, 3, 0, 40'd0);

    q = '{16'd2, 16'd3, 16'd4, 16'd5, 16'hFFFF, 16'd7};
    run_job("stall_bp", 3, 40, 10, 0, 40'd19);

    q = '{16'd2, 16'd3, 16'd4, 16'd5, 16'hFFFF, 16'd7};
    run_job("ign_start", 3, 0, 0, 1, 40'd19);
    q = '{16'd10, 16'd10};
    run_job("back2back", 1, 0, 0, 0, 40'd100);

    // Reset asserted between edges while waiting for X.
    q = '{16'd9, 16'd9, 16'd9, 16'd9};
    start = 1'b1;
    vec_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    src_vld = 1'b1;
    src_data = 16'd9;
    @(negedge clk);
    src_vld = 1'b0;
    chk("pre-reset busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async src_rdy", 64'(src_rdy), 64'd0);
    chk("async busy", 64'(busy), 64'd0);
    chk("async result_vld", 64'(result_vld), 64'd0);
    chk("async result_data", 64'(result_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q = '{16'd6, 16'd7};
    run_job("post_reset", 1, 0, 0, 0, 40'd42);

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(8, 1);
      q.delete();
      for (int j = 0; j < 2 * n; j++) begin
        k = $urandom_range(3);
        if (k == 0) q.push_back(16'h8000);
        else if (k == 1) q.push_back(16'h7FFF);
        else q.push_back(16'($urandom));
      end
      run_job($sformatf("rand%0d", r), n, $urandom_range(50),
              $urandom_range(3), r[0], model());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_engine.md
# dot_engine

Streaming dot-product stage directly downstream of `fetch_engine` in the GPU datapath. Consumes the interleaved weight/activation word stream that `fetch_engine` emits on its `src_*` port (W0, X0, W1, X1, …), multiply-accumulates `vec_len` pairs with signed arithmetic, and presents one result word on a valid/ready port that `gpu_top` drives out as `result_vld/result_rdy/result_data`. One job runs at a time. `start` is pulsed by `gpu_top` on the same `FETCH_ENGINE_RUN` command that starts `fetch_engine`.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of each W/X word; two's-complement signed.
- `ACC_WIDTH`, 40, accumulator and result width; must be ≥ 2*DATA_WIDTH.
- `LEN_WIDTH`, 16, width of the pair count.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle job start; sampled only in IDLE.
- `vec_len`  in  LEN_WIDTH  number of W/X pairs; latched when `start` is accepted.
- `src_vld`  in  1  upstream word valid.
- `src_rdy`  out  1  this block accepts a word.
- `src_data`  in  DATA_WIDTH  upstream word.
- `result_vld`  out  1  result word valid.
- `result_rdy`  in  1  downstream accepts the result.
- `result_data`  out  ACC_WIDTH  signed dot product.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, GET_W, GET_X, RESULT.
- IDLE:
  - If `start`=1 and `vec_len`≠0: clear the accumulator, latch `vec_len` into the remaining-count register, then go to GET_W.
  - If `start`=1 and `vec_len`=0: load `result_data`=0 and go directly to RESULT.
- GET_W: `src_rdy`=1. On handshake (`src_vld & src_rdy`), latch `src_data` into the W register and go to GET_X.
- GET_X: `src_rdy`=1. On handshake:
  - Form the sign-extended product W*X (2*DATA_WIDTH bits, sign-extended to ACC_WIDTH).
  - Update `acc <= acc + product`, modulo 2^ACC_WIDTH (wraps; no saturation, no overflow flag).
  - Decrement the remaining count.
  - If the count was 1: load `result_data <= acc + product` and go to RESULT. Otherwise go to GET_W.
- RESULT: `result_vld`=1 and `result_data` is held stable. On `result_rdy`=1, go to IDLE.
- `start` in any non-IDLE state is ignored. It does not restart or queue a job.
- `src_rdy`=0 in IDLE and RESULT. Words presented upstream in those states are not consumed.
- Reset mid-job: the job is abandoned, and all state returns to the reset values below. Partially consumed stream words are not recovered; upstream must also be reset.

## Timing
- Reset values: state=IDLE, `src_rdy`=0, `result_vld`=0, `result_data`=0, `busy`=0, accumulator=0, count=0, W register=0.
- `src_rdy`, `result_vld` and `busy` are decoded from registered state only. There is no combinational path from `src_vld` to `src_rdy`, or from `result_rdy` to `result_vld`.
- Throughput: one word accepted per cycle while `src_vld` is held high. A job of N pairs takes at least 2N cycles in GET_W/GET_X.
- Latency: the final X is accepted in cycle t; `result_vld`=1 in cycle t+1.
- From `start` accepted in cycle t:
  - `busy`=1 and `src_rdy`=1 from cycle t+1.
  - When `vec_len`=0, `result_vld`=1 in cycle t+1 instead.
- The result handshake completes in the cycle `result_rdy`=1. The block is in IDLE the next cycle and can accept a new `start` there. Minimum gap between jobs is one IDLE cycle.
- Back-pressure: `result_rdy` held low keeps `result_vld` and `result_data` stable indefinitely.
- Bubbles: `src_vld`=0 in GET_W/GET_X stalls with no state change.

## Test plan
- Basic: `vec_len`=3, stream W/X = 2,3, 4,5, -1,7 with `src_vld` held high -> `result_data`=19, `result_vld` exactly one cycle after the 6th handshake, `busy` high throughout.
- Signed extremes: `vec_len`=2, W/X = 0x8000,0x8000, 0x7FFF,0x8000 -> `result_data` = 1073741824 - 1073709056 = 32768.
- Zero length: `start` with `vec_len`=0 -> `result_vld` next cycle with `result_data`=0, and no `src_rdy` assertion at any point.
- Stalls and back-pressure: randomized `src_vld` bubbles plus `result_rdy` held low for 10 cycles -> same result as the unstalled run, and `result_data` stable while `result_vld`=1 and `result_rdy`=0.
- Ignored start and back-to-back jobs: pulse `start` during GET_X -> no effect. Issue a second job on the first IDLE cycle after the result handshake -> correct independent result, with the accumulator cleared.
- Async reset mid-job: assert `rst_n`=0 between clock edges in GET_X -> outputs reach reset values without a clock edge. A subsequent job with `vec_len`=1, W/X = 6,7 -> `result_data`=42.
